// File: rtl/cam_luma_capture_pkg.sv
// Shared camera definitions: capture FSM states, default sensor/window geometry
// and a small saturating-increment helper.
package cam_luma_capture_pkg;

    localparam int CAM_H_PIX    = 320;
    localparam int CAM_V_LINES  = 240;
    localparam int CAM_WIN_X0   = 96;
    localparam int CAM_WIN_Y0   = 56;
    localparam int CAM_WIN_SIZE = 128;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BLANK = 2'd2,
        ST_LINE  = 2'd3
    } cam_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic [7:0] lim);
        return (v < lim) ? v + 8'd1 : v;
    endfunction

endpackage

// File: rtl/cam_window_gate.sv
// Crop-window qualification of the registered pixel stream; purely combinational
// so the window strobes stay aligned with pix_valid.
module cam_window_gate
    import cam_luma_capture_pkg::*;
#(
    parameter int WIN_X0   = CAM_WIN_X0,
    parameter int WIN_Y0   = CAM_WIN_Y0,
    parameter int WIN_SIZE = CAM_WIN_SIZE
) (
    input  logic       pix_valid,
    input  logic [8:0] col,
    input  logic [7:0] row,
    output logic       win_valid,
    output logic       win_line_start,
    output logic       win_line_end
);

    // One extra bit on each side so WIN_X0+WIN_SIZE cannot wrap.
    localparam logic [9:0] X_LO   = 10'(WIN_X0);
    localparam logic [9:0] X_HI   = 10'(WIN_X0 + WIN_SIZE);
    localparam logic [9:0] X_LAST = 10'(WIN_X0 + WIN_SIZE - 1);
    localparam logic [8:0] Y_LO   = 9'(WIN_Y0);
    localparam logic [8:0] Y_HI   = 9'(WIN_Y0 + WIN_SIZE);

    logic [9:0] col_w;
    logic [8:0] row_w;
    logic       in_x;
    logic       in_y;

    always_comb begin
        col_w          = {1'b0, col};
        row_w          = {1'b0, row};
        in_x           = (col_w >= X_LO) && (col_w < X_HI);
        in_y           = (row_w >= Y_LO) && (row_w < Y_HI);
        win_valid      = pix_valid && in_x && in_y;
        win_line_start = win_valid && (col_w == X_LO);
        win_line_end   = win_valid && (col_w == X_LAST);
    end

endmodule

// File: rtl/cam_luma_capture.sv
// Camera luma capture: extracts the Y byte from a YUYV/UYVY stream, tracks
// column/row, flags malformed lines/frames and gates a crop window.
module cam_luma_capture
    import cam_luma_capture_pkg::*;
#(
    parameter int H_PIX    = CAM_H_PIX,
    parameter int V_LINES  = CAM_V_LINES,
    parameter int WIN_X0   = CAM_WIN_X0,
    parameter int WIN_Y0   = CAM_WIN_Y0,
    parameter int WIN_SIZE = CAM_WIN_SIZE,
    parameter int Y_PHASE  = 0
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       href,
    input  logic [7:0] cam_data,
    input  logic       capture_en,
    output logic [7:0] pix_data,
    output logic       pix_valid,
    output logic       win_valid,
    output logic [8:0] col,
    output logic [7:0] row,
    output logic       win_line_start,
    output logic       win_line_end,
    output logic       frame_start,
    output logic       frame_done,
    output logic       line_err,
    output logic       frame_err
);

    localparam logic [9:0] H_LIM = 10'(H_PIX);
    localparam logic [7:0] V_LIM = 8'(V_LINES);
    localparam logic       Y_SEL = 1'(Y_PHASE);

    cam_state_e state_q, state_d;
    logic       vsync_prev_q;
    logic       phase_q, phase_d;
    logic [9:0] cnt_q, cnt_d;
    logic [7:0] pix_data_q, pix_data_d;
    logic [8:0] col_q, col_d;
    logic [7:0] row_q, row_d;
    logic       pix_valid_q, pix_valid_d;
    logic       frame_start_q, frame_start_d;
    logic       frame_done_q, frame_done_d;
    logic       line_err_q, line_err_d;
    logic       frame_err_q, frame_err_d;
    logic       take_byte;
    logic       cur_phase;

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        cnt_d         = cnt_q;
        pix_data_d    = pix_data_q;
        col_d         = col_q;
        row_d         = row_q;
        pix_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        line_err_d    = line_err_q;
        frame_err_d   = frame_err_q;
        take_byte     = 1'b0;
        cur_phase     = 1'b0;

        case (state_q)
            ST_SYNC: begin
                if (vsync) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (vsync_prev_q && !vsync && capture_en) begin
                    state_d       = ST_BLANK;
                    frame_start_d = 1'b1;
                    row_d         = '0;
                    col_d         = '0;
                    cnt_d         = '0;
                end
            end
            ST_BLANK: begin
                if (vsync) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end else if (href) begin
                    // The byte that raises href is the first of the line (phase 0).
                    state_d   = ST_LINE;
                    take_byte = 1'b1;
                    cur_phase = 1'b0;
                end
            end
            ST_LINE: begin
                if (vsync) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                    col_d       = '0;
                    cnt_d       = '0;
                end else if (!href) begin
                    state_d = ST_BLANK;
                    if (cnt_q != H_LIM) line_err_d = 1'b1;
                    row_d   = sat_inc8(row_q, V_LIM);
                    col_d   = '0;
                    cnt_d   = '0;
                end else begin
                    take_byte = 1'b1;
                    cur_phase = phase_q;
                end
            end
            default: state_d = ST_SYNC;
        endcase

        if (take_byte) begin
            phase_d = ~cur_phase;
            if (cur_phase == Y_SEL) begin
                if ((cnt_q < H_LIM) && (row_q < V_LIM)) begin
                    pix_valid_d = 1'b1;
                    pix_data_d  = cam_data;
                    col_d       = cnt_q[8:0];
                end
                // Saturate one past H_PIX so over-long lines stay detectable.
                if (cnt_q <= H_LIM) cnt_d = cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_SYNC;
            vsync_prev_q  <= 1'b0;
            phase_q       <= 1'b0;
            cnt_q         <= '0;
            pix_data_q    <= '0;
            col_q         <= '0;
            row_q         <= '0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            vsync_prev_q  <= vsync;
            phase_q       <= phase_d;
            cnt_q         <= cnt_d;
            pix_data_q    <= pix_data_d;
            col_q         <= col_d;
            row_q         <= row_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            line_err_q    <= line_err_d;
            frame_err_q   <= frame_err_d;
        end
    end

    cam_window_gate #(
        .WIN_X0  (WIN_X0),
        .WIN_Y0  (WIN_Y0),
        .WIN_SIZE(WIN_SIZE)
    ) u_window_gate (
        .pix_valid     (pix_valid_q),
        .col           (col_q),
        .row           (row_q),
        .win_valid     (win_valid),
        .win_line_start(win_line_start),
        .win_line_end  (win_line_end)
    );

    assign pix_data    = pix_data_q;
    assign pix_valid   = pix_valid_q;
    assign col         = col_q;
    assign row         = row_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign line_err    = line_err_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_cam_luma_capture.sv
// Scoreboard bench for cam_luma_capture on a scaled-down geometry; a YUYV and a
// UYVY instance share the same camera stimulus.
module tb_cam_luma_capture;
    import cam_luma_capture_pkg::*;

    localparam int TH  = 16;
    localparam int TV  = 12;
    localparam int TX0 = 4;
    localparam int TY0 = 3;
    localparam int TS  = 8;

    logic       pclk = 1'b0;
    logic       reset = 1'b1;
    logic       vsync = 1'b0;
    logic       href = 1'b0;
    logic       capture_en = 1'b0;
    logic [7:0] cam_data = '0;

    logic [7:0] pd0, pd1, row0, row1;
    logic [8:0] col0, col1;
    logic pv0, wv0, wls0, wle0, fs0, fd0, le0, fe0;
    logic pv1, wv1, wls1, wle1, fs1, fd1, le1, fe1;

    cam_luma_capture #(
        .H_PIX(TH), .V_LINES(TV), .WIN_X0(TX0), .WIN_Y0(TY0), .WIN_SIZE(TS), .Y_PHASE(0)
    ) dut0 (
        .pclk(pclk), .reset(reset), .vsync(vsync), .href(href), .cam_data(cam_data),
        .capture_en(capture_en), .pix_data(pd0), .pix_valid(pv0), .win_valid(wv0),
        .col(col0), .row(row0), .win_line_start(wls0), .win_line_end(wle0),
        .frame_start(fs0), .frame_done(fd0), .line_err(le0), .frame_err(fe0)
    );

    cam_luma_capture #(
        .H_PIX(TH), .V_LINES(TV), .WIN_X0(TX0), .WIN_Y0(TY0), .WIN_SIZE(TS), .Y_PHASE(1)
    ) dut1 (
        .pclk(pclk), .reset(reset), .vsync(vsync), .href(href), .cam_data(cam_data),
        .capture_en(capture_en), .pix_data(pd1), .pix_valid(pv1), .win_valid(wv1),
        .col(col1), .row(row1), .win_line_start(wls1), .win_line_end(wle1),
        .frame_start(fs1), .frame_done(fd1), .line_err(le1), .frame_err(fe1)
    );

    always #5 pclk = ~pclk;

    int ncyc = 0;
    always @(posedge pclk) ncyc <= ncyc + 1;

    typedef struct {
        logic [7:0] d;
        logic [8:0] c;
        logic [7:0] r;
        int         t;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    bit   ew0, ew1;

    int n_pv0 = 0, n_pv1 = 0, n_wv = 0, n_wls = 0, n_wle = 0, n_fs = 0, n_fd = 0, sb_bad = 0;
    int b_pv0, b_pv1, b_wv, b_wls, b_wle, b_fs, b_fd, b_bad;
    int vectors = 0;
    int miscompares = 0;

    function automatic bit in_win(input logic [8:0] c, input logic [7:0] r);
        return (int'(c) >= TX0) && (int'(c) < TX0 + TS) && (int'(r) >= TY0) && (int'(r) < TY0 + TS);
    endfunction

    // Scoreboard monitor: pops one expectation per pix_valid and checks data,
    // position, window strobes and exact 1-pclk latency.
    always @(negedge pclk) begin
        if (fs0) n_fs++;
        if (fd0) n_fd++;
        if (wv0) n_wv++;
        if (wls0) n_wls++;
        if (wle0) n_wle++;
        if (pv0) begin
            n_pv0++;
            if (q0.size() == 0) begin
                sb_bad++;
                $display("FAIL sb0_unexpected: got pix_valid d=%h col=%0d row=%0d, expected no pixel", pd0, col0, row0);
            end else begin
                e0  = q0.pop_front();
                ew0 = in_win(e0.c, e0.r);
                if ({pd0, col0, row0, wv0, wls0, wle0} !== {e0.d, e0.c, e0.r, ew0,
                        ew0 && (int'(e0.c) == TX0), ew0 && (int'(e0.c) == TX0 + TS - 1)} || ncyc != e0.t) begin
                    sb_bad++;
                    $display("FAIL sb0_pixel: got d=%h col=%0d row=%0d win=%b%b%b cyc=%0d, expected d=%h col=%0d row=%0d win=%b cyc=%0d",
                             pd0, col0, row0, wv0, wls0, wle0, ncyc, e0.d, e0.c, e0.r, ew0, e0.t);
                end
            end
        end else if (wv0 || wls0 || wle0) begin
            sb_bad++;
            $display("FAIL sb0_win_idle: got win=%b%b%b, expected 000 without pix_valid", wv0, wls0, wle0);
        end
        if (pv1) begin
            n_pv1++;
            if (q1.size() == 0) begin
                sb_bad++;
                $display("FAIL sb1_unexpected: got pix_valid d=%h col=%0d row=%0d, expected no pixel", pd1, col1, row1);
            end else begin
                e1  = q1.pop_front();
                ew1 = in_win(e1.c, e1.r);
                if ({pd1, col1, row1, wv1} !== {e1.d, e1.c, e1.r, ew1} || ncyc != e1.t) begin
                    sb_bad++;
                    $display("FAIL sb1_pixel: got d=%h col=%0d row=%0d win=%b cyc=%0d, expected d=%h col=%0d row=%0d win=%b cyc=%0d",
                             pd1, col1, row1, wv1, ncyc, e1.d, e1.c, e1.r, ew1, e1.t);
                end
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic snap();
        b_pv0 = n_pv0; b_pv1 = n_pv1; b_wv = n_wv; b_wls = n_wls;
        b_wle = n_wle; b_fs = n_fs; b_fd = n_fd; b_bad = sb_bad;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        q0.delete();
        q1.delete();
        reset = 1'b0;
        tick();
    endtask

    // One camera frame; a negative line index disables the corresponding event.
    task automatic drive_frame(input int n_lines, input int short_line, input int short_len,
                               input int long_line, input int long_len, input int abort_line,
                               input int abort_byte, input int rst_line, input int rst_byte,
                               input bit cap, input bit pat);
        bit   live;
        int   len;
        exp_t e;
        live       = cap;
        vsync      = 1'b1;
        href       = 1'b0;
        capture_en = cap;
        repeat (4) tick();
        vsync = 1'b0;
        repeat (3) tick();
        for (int l = 0; l < n_lines; l++) begin
            len = 2 * TH;
            if (l == short_line) len = short_len;
            if (l == long_line) len = long_len;
            for (int b = 0; b < len; b++) begin
                if (l == abort_line && b == abort_byte) begin
                    vsync = 1'b1;
                    href  = 1'b0;
                    repeat (4) tick();
                    return;
                end
                if (l == rst_line && b == rst_byte) begin
                    reset = 1'b1;
                    #1;
                    vectors++;
                    if ({pd0, col0, row0, pv0, wv0, wls0, wle0, fs0, fd0, le0, fe0,
                         pd1, col1, row1, pv1, wv1, wls1, wle1, fs1, fd1, le1, fe1} !== '0) begin
                        miscompares++;
                        $display("FAIL midline_reset_outputs: got pv=%b col=%0d row=%0d le=%b fe=%b, expected all zero",
                                 pv0, col0, row0, le0, fe0);
                    end
                    vectors++;
                    if (dut0.state_q !== ST_SYNC) begin
                        miscompares++;
                        $display("FAIL midline_reset_state: got %0d, expected %0d", dut0.state_q, ST_SYNC);
                    end
                    q0.delete();
                    q1.delete();
                    live = 1'b0;
                    repeat (2) @(posedge pclk);
                    #1;
                    reset = 1'b0;
                end
                href     = 1'b1;
                cam_data = pat ? ((b % 2 == 0) ? 8'h11 : 8'hA5) : 8'((l * 29 + b * 7 + 3) & 255);
                if (live && (b / 2) < TH && l < TV) begin
                    e.d = cam_data;
                    e.c = 9'(b / 2);
                    e.r = 8'(l);
                    e.t = ncyc + 1;
                    if (b % 2 == 0) q0.push_back(e);
                    else q1.push_back(e);
                end
                tick();
            end
            href = 1'b0;
            repeat (4) tick();
        end
        repeat (2) tick();
        vsync = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({pd0, col0, row0, pv0, wv0, wls0, wle0, fs0, fd0, le0, fe0} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs0: got pd=%h col=%0d row=%0d pv=%b, expected all zero", pd0, col0, row0, pv0);
        end
        vectors++;
        if ({pd1, col1, row1, pv1, wv1, wls1, wle1, fs1, fd1, le1, fe1} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs1: got pd=%h col=%0d row=%0d pv=%b, expected all zero", pd1, col1, row1, pv1);
        end
        vectors++;
        if (dut0.state_q !== ST_SYNC) begin
            miscompares++;
            $display("FAIL reset_state: got %0d, expected %0d", dut0.state_q, ST_SYNC);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_normal_frame();
        int    got[11];
        int    want[11];
        string nm[11] = '{"pix_valid0", "pix_valid1", "win_valid", "win_line_start", "win_line_end",
                          "frame_start", "frame_done", "line_err", "frame_err", "sb_errors", "sb_pending"};
        do_reset();
        snap();
        drive_frame(TV, -1, 0, -1, 0, -1, 0, -1, 0, 1'b1, 1'b0);
        got  = '{n_pv0 - b_pv0, n_pv1 - b_pv1, n_wv - b_wv, n_wls - b_wls, n_wle - b_wle,
                 n_fs - b_fs, n_fd - b_fd, int'(le0), int'(fe0), sb_bad - b_bad, q0.size() + q1.size()};
        want = '{TH * TV, TH * TV, TS * TS, TS, TS, 1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 11; i++) begin
            vectors++;
            if (got[i] !== want[i]) begin
                miscompares++;
                $display("FAIL normal_%s: got %0d, expected %0d", nm[i], got[i], want[i]);
            end
        end
    endtask

    task automatic test_short_line();
        int    got[5];
        int    want[5];
        string nm[5] = '{"line_err", "frame_err", "frame_done", "sb_errors", "sb_pending"};
        do_reset();
        snap();
        drive_frame(TV, 10, 2 * TH - 8, -1, 0, -1, 0, -1, 0, 1'b1, 1'b0);
        got  = '{int'(le0), int'(fe0), n_fd - b_fd, sb_bad - b_bad, q0.size() + q1.size()};
        want = '{1, 0, 1, 0, 0};
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (got[i] !== want[i]) begin
                miscompares++;
                $display("FAIL short_%s: got %0d, expected %0d", nm[i], got[i], want[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int    got[5];
        int    want[5];
        string nm[5] = '{"pix_valid0", "line_err", "frame_done", "sb_errors", "sb_pending"};
        do_reset();
        snap();
        drive_frame(TV + 2, -1, 0, 3, 2 * TH + 6, -1, 0, -1, 0, 1'b1, 1'b0);
        got  = '{n_pv0 - b_pv0, int'(le0), n_fd - b_fd, sb_bad - b_bad, q0.size() + q1.size()};
        want = '{TH * TV, 1, 1, 0, 0};
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (got[i] !== want[i]) begin
                miscompares++;
                $display("FAIL overflow_%s: got %0d, expected %0d", nm[i], got[i], want[i]);
            end
        end
    endtask

    task automatic test_abort();
        int    got[6];
        int    want[6];
        string nm[6] = '{"frame_err", "line_err", "frame_done", "state", "sb_errors", "sb_pending"};
        do_reset();
        snap();
        drive_frame(TV, -1, 0, -1, 0, 5, 20, -1, 0, 1'b1, 1'b0);
        got  = '{int'(fe0), int'(le0), n_fd - b_fd, int'(dut0.state_q), sb_bad - b_bad, q0.size() + q1.size()};
        want = '{1, 0, 0, int'(ST_IDLE), 0, 0};
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (got[i] !== want[i]) begin
                miscompares++;
                $display("FAIL abort_%s: got %0d, expected %0d", nm[i], got[i], want[i]);
            end
        end
    endtask

    task automatic test_capture_disable();
        int    got[7];
        int    want[7];
        string nm[7] = '{"off_pix_valid", "off_frame_start", "on_pix_valid", "on_frame_start",
                         "on_frame_done", "sb_errors", "sb_pending"};
        do_reset();
        snap();
        drive_frame(TV, -1, 0, -1, 0, -1, 0, -1, 0, 1'b0, 1'b0);
        got[0] = n_pv0 - b_pv0 + n_pv1 - b_pv1;
        got[1] = n_fs - b_fs;
        snap();
        drive_frame(TV, -1, 0, -1, 0, -1, 0, -1, 0, 1'b1, 1'b0);
        got[2] = n_pv0 - b_pv0;
        got[3] = n_fs - b_fs;
        got[4] = n_fd - b_fd;
        got[5] = sb_bad - b_bad;
        got[6] = q0.size() + q1.size();
        want = '{0, 0, TH * TV, 1, 1, 0, 0};
        for (int i = 0; i < 7; i++) begin
            vectors++;
            if (got[i] !== want[i]) begin
                miscompares++;
                $display("FAIL capdis_%s: got %0d, expected %0d", nm[i], got[i], want[i]);
            end
        end
    endtask

    task automatic test_midline_reset();
        int    got[6];
        int    want[6];
        string nm[6] = '{"rst_frame_sb_errors", "pix_valid0", "frame_start", "frame_done", "line_err", "sb_pending"};
        do_reset();
        snap();
        drive_frame(TV, 2, 2 * TH - 4, -1, 0, -1, 0, 7, 10, 1'b1, 1'b0);
        got[0] = sb_bad - b_bad;
        snap();
        drive_frame(TV, -1, 0, -1, 0, -1, 0, -1, 0, 1'b1, 1'b0);
        got[1] = n_pv0 - b_pv0;
        got[2] = n_fs - b_fs;
        got[3] = n_fd - b_fd;
        got[4] = int'(le0);
        got[5] = q0.size() + q1.size() + sb_bad - b_bad;
        want = '{0, TH * TV, 1, 1, 0, 0};
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (got[i] !== want[i]) begin
                miscompares++;
                $display("FAIL midrst_%s: got %0d, expected %0d", nm[i], got[i], want[i]);
            end
        end
    endtask

    task automatic test_y_phase();
        int    got[4];
        int    want[4];
        string nm[4] = '{"uyvy_pix_valid", "last_pix_data", "sb_errors", "sb_pending"};
        do_reset();
        snap();
        drive_frame(TV, -1, 0, -1, 0, -1, 0, -1, 0, 1'b1, 1'b1);
        got  = '{n_pv1 - b_pv1, int'(pd1), sb_bad - b_bad, q0.size() + q1.size()};
        want = '{TH * TV, 8'hA5, 0, 0};
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (got[i] !== want[i]) begin
                miscompares++;
                $display("FAIL yphase_%s: got %0d, expected %0d", nm[i], got[i], want[i]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_normal_frame();
        test_short_line();
        test_overflow();
        test_abort();
        test_capture_disable();
        test_midline_reset();
        test_y_phase();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cam_luma_capture.md
CAM_LUMA_CAPTURE -- requirements
Module: cam_luma_capture

Interface
REQ-001 SHALL have parameter H_PIX, default 320, meaning luma pixels per active line.
REQ-002 SHALL have parameter V_LINES, default 240, meaning active lines per frame.
REQ-003 SHALL have parameter WIN_X0, default 96, meaning first window column.
REQ-004 SHALL have parameter WIN_Y0, default 56, meaning first window row.
REQ-005 SHALL have parameter WIN_SIZE, default 128, meaning window width and height.
REQ-006 SHALL have parameter Y_PHASE, default 0, meaning byte phase carrying luma (0 selects YUYV, 1 selects UYVY).
REQ-007 SHALL have port pclk, input, 1, the single camera pixel clock; all logic is on its rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port vsync, input, 1, camera frame sync; high means vertical blanking.
REQ-010 SHALL have port href, input, 1, camera line valid; high means active bytes.
REQ-011 SHALL have port cam_data, input, 8, camera byte bus.
REQ-012 SHALL have port capture_en, input, 1, capture enable, sampled only at frame start.
REQ-013 SHALL have port pix_data, output, 8, registered luma byte.
REQ-014 SHALL have port pix_valid, output, 1, one-cycle strobe for every luma pixel of an accepted line.
REQ-015 SHALL have port win_valid, output, 1, pix_valid qualified by the crop window.
REQ-016 SHALL have port col, output, 9, column index of the current pix_data.
REQ-017 SHALL have port row, output, 8, row index of the current pix_data.
REQ-018 SHALL have port win_line_start, output, 1, strobe coincident with the first window pixel of a row.
REQ-019 SHALL have port win_line_end, output, 1, strobe coincident with the last window pixel of a row.
REQ-020 SHALL have port frame_start, output, 1, one-cycle strobe at accepted frame start.
REQ-021 SHALL have port frame_done, output, 1, one-cycle strobe at accepted frame end.
REQ-022 SHALL have port line_err, output, 1, sticky flag for a short or long line.
REQ-023 SHALL have port frame_err, output, 1, sticky flag for a frame aborted mid-line.

Function
REQ-024 SHALL implement states SYNC, IDLE, BLANK and LINE.
REQ-025 SYNC SHALL be entered on reset and SHALL move to IDLE only after vsync has been observed high.
REQ-026 SHALL move from IDLE to BLANK on the vsync falling edge when capture_en=1, pulsing frame_start the next cycle; when capture_en=0 it SHALL stay in IDLE.
REQ-027 SHALL move from BLANK to LINE on href high; from LINE to BLANK on href low; from BLANK to IDLE on vsync high, pulsing frame_done.
REQ-028 In LINE, a byte-phase bit SHALL clear on entry and toggle every pclk; the byte with phase==Y_PHASE SHALL be luma.
REQ-029 Luma latency SHALL be exactly 1 pclk: pix_data, pix_valid, col and row SHALL be registered together.
REQ-030 col SHALL run 0..H_PIX-1 and row SHALL run 0..V_LINES-1.
REQ-031 Luma bytes beyond H_PIX-1 in a line, and every line after row V_LINES-1, SHALL produce no pix_valid.
REQ-032 On the LINE-to-BLANK transition, row SHALL increment saturating at V_LINES, col SHALL clear, and line_err SHALL set if the luma count differs from H_PIX.
REQ-033 When vsync rises while in LINE, the block SHALL abort to IDLE, set frame_err and SHALL NOT pulse frame_done.
REQ-034 win_valid SHALL equal pix_valid AND WIN_X0<=col<WIN_X0+WIN_SIZE AND WIN_Y0<=row<WIN_Y0+WIN_SIZE.
REQ-035 win_line_start SHALL pulse with win_valid at col=WIN_X0, and win_line_end SHALL pulse with win_valid at col=WIN_X0+WIN_SIZE-1.
REQ-036 Window comparisons SHALL use unsigned arithmetic at 9/8-bit widths with no wrap.
REQ-037 line_err and frame_err SHALL clear only on reset.

Reset
REQ-038 Asserting reset SHALL force state SYNC, all strobes 0, pix_data=0, col=0, row=0, line_err=0 and frame_err=0 immediately, mid-line included.
REQ-039 After reset deasserts, no pix_valid SHALL occur before a complete vsync high-to-low sequence.

Structure
REQ-040 The shared camera package SHALL hold the state enumeration and the default geometry constants (320, 240, 96, 56, 128).
REQ-041 The window qualification SHALL be one sub-module, cam_window_gate.

Verification
REQ-042 Normal frame: YUYV, 240 lines of 640 bytes -> 76800 pix_valid, 16384 win_valid, 128 win_line_start, 1 frame_start, 1 frame_done, no errors.
REQ-043 Short line: line 10 has 600 bytes -> line_err=1, row continues to 11, frame_done still pulses.
REQ-044 Abort: vsync rises at byte 200 of line 5 -> frame_err=1, no frame_done, state IDLE.
REQ-045 capture_en=0 at vsync fall -> zero pix_valid for the whole frame; capture_en=1 at the next frame -> normal capture.
REQ-046 Reset asserted mid-line 100 -> all outputs 0 the same cycle; first pix_valid only after the next full vsync cycle.
REQ-047 Y_PHASE=1 with bytes 0x11,0xA5 repeated -> every pix_data=0xA5, arriving 1 pclk after the byte.
